// File: rtl/complex_delay_line.sv
// Complex (real/imag) sample delay line with a selectable delay of 0..DEPTH accepted samples.
//
// A DEPTH-entry shift register advances only on beats (in_valid=1 and flush=0). On a beat the
// output registers load either the incoming sample (D=0) or the pre-shift history tap h[D-1].
// out_valid is raised on a beat only when enough history exists for the requested delay.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset, clears all state
//   in_valid   input sample accepted this cycle
//   in_real    signed real part of input sample
//   in_imag    signed imaginary part of input sample
//   delay_sel  requested delay in accepted samples, clamped to DEPTH
//   flush      synchronous clear of history and outputs, wins over in_valid
//   out_valid  registered, delayed sample valid
//   out_real   registered real part of delayed sample
//   out_imag   registered imaginary part of delayed sample
//   fill_cnt   registered count of samples held in history, saturates at DEPTH
module complex_delay_line #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SEL_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_real,
  input  logic signed [WIDTH-1:0] in_imag,
  input  logic        [SEL_W-1:0] delay_sel,
  input  logic                    flush,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_real,
  output logic signed [WIDTH-1:0] out_imag,
  output logic        [SEL_W-1:0] fill_cnt
);

  logic signed [WIDTH-1:0] h_real [DEPTH];
  logic signed [WIDTH-1:0] h_imag [DEPTH];

  logic                    beat;
  logic        [SEL_W-1:0] d_eff;
  logic signed [WIDTH-1:0] tap_real;
  logic signed [WIDTH-1:0] tap_imag;

  assign beat = in_valid & ~flush;

  // Clamp out-of-range requests to the deepest tap.
  always_comb begin
    d_eff = delay_sel;
    if (32'(delay_sel) > DEPTH) begin
      d_eff = SEL_W'(DEPTH);
    end
  end

  // Tap mux: D=0 bypasses the history, D>=1 selects the pre-shift entry h[D-1].
  always_comb begin
    tap_real = in_real;
    tap_imag = in_imag;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (d_eff == SEL_W'(k + 1)) begin
        tap_real = h_real[k];
        tap_imag = h_imag[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        h_real[k] <= '0;
        h_imag[k] <= '0;
      end
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      fill_cnt  <= '0;
    end else if (flush) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        h_real[k] <= '0;
        h_imag[k] <= '0;
      end
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      fill_cnt  <= '0;
    end else if (beat) begin
      h_real[0] <= in_real;
      h_imag[0] <= in_imag;
      for (int k = 1; k < int'(DEPTH); k++) begin
        h_real[k] <= h_real[k-1];
        h_imag[k] <= h_imag[k-1];
      end
      out_real  <= tap_real;
      out_imag  <= tap_imag;
      // Compared against the pre-update count, so a delay increase with enough
      // existing history produces no gap.
      out_valid <= (fill_cnt >= d_eff);
      if (32'(fill_cnt) < DEPTH) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end else begin
      // Idle cycle: data holds, valid drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_complex_delay_line.sv
// Directed self-checking bench for complex_delay_line (WIDTH=14, DEPTH=16).
module tb_complex_delay_line;

  localparam int unsigned WIDTH = 14;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SEL_W = 5;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_real;
  logic signed [WIDTH-1:0] in_imag;
  logic        [SEL_W-1:0] delay_sel;
  logic                    flush;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_real;
  logic signed [WIDTH-1:0] out_imag;
  logic        [SEL_W-1:0] fill_cnt;

  int compared;
  int mismatched;

  complex_delay_line #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .SEL_W(SEL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .delay_sel(delay_sel),
    .flush    (flush),
    .out_valid(out_valid),
    .out_real (out_real),
    .out_imag (out_imag),
    .fill_cnt (fill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input int re, input int im);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".real"}, 32'(out_real), re);
    check({tag, ".imag"}, 32'(out_imag), im);
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input int re, input int im);
    in_valid = v;
    in_real  = WIDTH'(re);
    in_imag  = WIDTH'(im);
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic v);
    flush    = 1'b1;
    in_valid = v;
    in_real  = 14'sd99;
    in_imag  = -14'sd99;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_real    = '0;
    in_imag    = '0;
    delay_sel  = '0;
    flush      = 1'b0;

    #2;
    check_out("reset", 1'b0, 0, 0);
    check("reset.fill", 32'(fill_cnt), 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);

    // D=0: pass-through with one cycle latency.
    delay_sel = 5'd0;
    step(1'b1, 1, -1);
    check_out("d0.b1", 1'b1, 1, -1);
    step(1'b1, 2, -2);
    check_out("d0.b2", 1'b1, 2, -2);
    step(1'b1, 3, -3);
    check_out("d0.b3", 1'b1, 3, -3);
    step(1'b0, 0, 0);
    check_out("d0.idle_hold", 1'b0, 3, -3);
    check("d0.fill", 32'(fill_cnt), 3);

    // D=3 on a clean history.
    do_flush(1'b0);
    check_out("flush1", 1'b0, 0, 0);
    check("flush1.fill", 32'(fill_cnt), 0);
    delay_sel = 5'd3;
    step(1'b1, 10, -10);
    check("d3.b1.valid", 32'(out_valid), 0);
    step(1'b1, 11, -11);
    check("d3.b2.valid", 32'(out_valid), 0);
    step(1'b1, 12, -12);
    check("d3.b3.valid", 32'(out_valid), 0);
    step(1'b1, 13, -13);
    check_out("d3.b4", 1'b1, 10, -10);
    step(1'b1, 14, -14);
    check_out("d3.b5", 1'b1, 11, -11);
    check("d3.fill", 32'(fill_cnt), 5);

    // D=2 with idle gaps: valid pattern 1,0,1,0,0,1.
    do_flush(1'b0);
    delay_sel = 5'd2;
    step(1'b1, 5, -5);
    check_out("gap.b1", 1'b0, 0, 0);
    step(1'b0, 0, 0);
    check_out("gap.i1", 1'b0, 0, 0);
    step(1'b1, 6, -6);
    check("gap.b2.valid", 32'(out_valid), 0);
    step(1'b0, 0, 0);
    check("gap.i2.valid", 32'(out_valid), 0);
    step(1'b0, 0, 0);
    check("gap.i3.valid", 32'(out_valid), 0);
    step(1'b1, 7, -7);
    check_out("gap.b3", 1'b1, 5, -5);
    step(1'b0, 0, 0);
    check_out("gap.i4_hold", 1'b0, 5, -5);
    check("gap.fill", 32'(fill_cnt), 3);

    // delay_sel beyond DEPTH clamps to 16; ramp 0..39.
    do_flush(1'b0);
    delay_sel = 5'd20;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, i, -i);
      if (i >= 16) begin
        check_out($sformatf("ramp.b%0d", i), 1'b1, i - 16, 16 - i);
      end else begin
        check($sformatf("ramp.b%0d.valid", i), 32'(out_valid), 0);
      end
      check($sformatf("ramp.b%0d.fill", i), 32'(fill_cnt), (i + 1 > 16) ? 16 : i + 1);
    end

    // Delay change with plenty of history: immediate valid, tap h[2] = 37.
    delay_sel = 5'd3;
    step(1'b1, 40, -40);
    check_out("dchg", 1'b1, 37, -37);

    // Flush colliding with in_valid, D=1.
    delay_sel = 5'd1;
    step(1'b1, 41, -41);
    check_out("pre_flush", 1'b1, 40, -40);
    do_flush(1'b1);
    check_out("flush_vs_valid", 1'b0, 0, 0);
    check("flush_vs_valid.fill", 32'(fill_cnt), 0);
    step(1'b1, 50, -50);
    check_out("post_flush.b1", 1'b0, 0, 0);
    check("post_flush.fill", 32'(fill_cnt), 1);
    step(1'b1, 51, -51);
    check_out("post_flush.b2", 1'b1, 50, -50);

    // Async reset mid-stream, between edges.
    step(1'b1, 52, -52);
    check_out("pre_rst", 1'b1, 51, -51);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_out("rst_async", 1'b0, 0, 0);
    check("rst_async.fill", 32'(fill_cnt), 0);
    #1;
    rst = 1'b1;
    @(negedge clk);
    step(1'b1, 60, -60);
    check_out("post_rst.b1", 1'b0, 0, 0);
    check("post_rst.fill", 32'(fill_cnt), 1);
    step(1'b1, 61, -61);
    check_out("post_rst.b2", 1'b1, 60, -60);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/complex_delay_line.md
COMPLEX_DELAY_LINE -- requirements
Module: complex_delay_line

Interface
REQ-001 The block SHALL have parameter WIDTH, default 14, giving the bit width of each signed real and imaginary sample.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the maximum delay in accepted samples; legal range is 1..256.
REQ-003 The block SHALL have parameter SEL_W, default $clog2(DEPTH+1), giving the width of delay_sel and fill_cnt.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of clk.
REQ-006 in_valid  input  1  marks in_real/in_imag as an accepted sample this cycle.
REQ-007 in_real  input  WIDTH (signed)  real part of the input sample.
REQ-008 in_imag  input  WIDTH (signed)  imaginary part of the input sample.
REQ-009 delay_sel  input  SEL_W  requested delay D in accepted samples, 0..DEPTH.
REQ-010 flush  input  1  synchronous clear of history and output.
REQ-011 out_valid  output  1  registered; marks out_real/out_imag as a valid delayed sample.
REQ-012 out_real  output  WIDTH (signed)  registered real part of the delayed sample.
REQ-013 out_imag  output  WIDTH (signed)  registered imaginary part of the delayed sample.
REQ-014 fill_cnt  output  SEL_W  registered count of samples held in history, saturating at DEPTH.

Function
REQ-015 The history SHALL be a DEPTH-entry complex shift register h[0..DEPTH-1] that advances only on beats, i.e. cycles with in_valid=1 and flush=0: h[0]<=input, h[k]<=h[k-1].
REQ-016 On a beat, the output registers SHALL load the input itself when D=0, and the pre-shift value h[D-1] when D>=1.
REQ-017 Result: the sample accepted on beat n SHALL appear on out_real/out_imag one clock after beat n+D.
REQ-018 If delay_sel exceeds DEPTH, the block SHALL use D=DEPTH.
REQ-019 On a beat, out_valid SHALL be set to 1 when fill_cnt (pre-update) >= D, and to 0 otherwise.
REQ-020 On a non-beat cycle, out_valid SHALL be 0 and out_real/out_imag SHALL hold their previous values.
REQ-021 On a beat, fill_cnt SHALL increment by 1, saturating at DEPTH; it SHALL NOT wrap.
REQ-022 Data SHALL pass bit-exact, with no arithmetic, rounding or sign modification.
REQ-023 delay_sel SHALL be sampled on every beat; a change takes effect on the first beat after it is applied, and history and fill_cnt are unaffected.
REQ-024 After a delay increase, out_valid SHALL follow REQ-019 against the existing fill_cnt, so there is no gap when enough history already exists.
REQ-025 When flush=1 on a rising edge, the block SHALL clear h[], out_real, out_imag, out_valid and fill_cnt to 0.
REQ-026 flush SHALL take priority over a simultaneous in_valid; the sample on that cycle is discarded.
REQ-027 There SHALL be no backpressure; the block SHALL accept one beat per cycle indefinitely.

Reset
REQ-028 While rst=0, the block SHALL hold h[]=0, out_real=0, out_imag=0, out_valid=0 and fill_cnt=0, taking effect asynchronously.
REQ-029 Reset asserted mid-stream SHALL discard all history.
REQ-030 After reset deasserts, the first beat SHALL behave exactly as the first beat after a flush.
REQ-031 Reset deassertion SHALL be synchronised to clk by the surrounding logic; the block itself SHALL add no reset synchroniser.

Verification
REQ-032 D=0, beats with samples (1,-1),(2,-2),(3,-3) on consecutive cycles -> outputs (1,-1),(2,-2),(3,-3) one cycle later each, with out_valid=1 on all three.
REQ-033 D=3, samples 10,11,12,13,14 (real; imaginary = negated real) on consecutive beats -> out_valid=0 for the first 3 beats, then (10,-10) after beat 4 and (11,-11) after beat 5; fill_cnt reaches 5.
REQ-034 D=2, beats with idle gaps (in_valid pattern 1,0,1,0,0,1) carrying 5,6,7 -> output 5 after the third beat only; out_valid=0 on all idle cycles; outputs hold value between beats.
REQ-035 DEPTH=16, delay_sel=20, 40 beats of ramp 0..39 -> out_valid from beat 17 onward, with output equal to input-16; fill_cnt saturates at 16.
REQ-036 Flush and in_valid both asserted on the same cycle mid-stream, D=1 -> all outputs 0, fill_cnt=0, and the next beat gives out_valid=0.
REQ-037 rst pulsed low between clock edges mid-stream -> outputs 0 immediately, before the next edge; post-reset behaviour matches REQ-030.
